// File: rtl/mac_pkg.sv
// Shared constants and state type for the MAC accumulation stage.
package mac_pkg;

    localparam int unsigned DefPw = 4;
    localparam int unsigned DefAw = 8;
    localparam int unsigned DefN  = 4;

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } mac_state_e;

    // Beat counter width: clog2(N), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_acc_add.sv
// AW-bit accumulator adder with carry out; clamps to all-ones when MAC_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^AW.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int unsigned PW = DefPw,
    parameter int unsigned AW = DefAw
) (
    input  logic [AW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] raw;

    assign raw   = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, b};
    assign carry = raw[AW];

`ifdef MAC_ACC_SAT_EN
    // Once clamped, any further non-zero addend carries again, so the sum stays pinned.
    assign sum = carry ? {AW{1'b1}} : raw[AW-1:0];
`else
    assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums N unsigned products per result and presents the sum on a valid/ready port.
// Overflow behaviour (wrap or clamp) is selected by MAC_ACC_SAT_EN in mac_acc_add.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned PW = DefPw,
    parameter int unsigned AW = DefAw,
    parameter int unsigned N  = DefN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic          out_ovf
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    mac_state_e    state_q;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    logic [AW-1:0] sum;
    logic          carry;

    mac_acc_add #(
        .PW(PW),
        .AW(AW)
    ) u_add (
        .a    (acc_q),
        .b    (in_p),
        .sum  (sum),
        .carry(carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            // Abort: any partial sum, pending result and concurrent beat are dropped.
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StAcc: begin
                    if (in_valid) begin
                        acc_q <= sum;
                        ovf_q <= ovf_q | carry;
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            state_q <= StHold;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q <= StAcc;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StHold);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule
